// File: rtl/gru_pkg.sv
// gru_pkg: shared encodings and default sizes for the VAD GRU gate scheduler and datapath.
package gru_pkg;

    localparam int N_IN_DEF    = 24;
    localparam int N_UNITS_DEF = 24;
    localparam int N_GATES_DEF = 3;

    localparam logic [1:0] GATE_Z = 2'd0;
    localparam logic [1:0] GATE_R = 2'd1;
    localparam logic [1:0] GATE_H = 2'd2;

    typedef enum logic [1:0] {
        SRC_BIAS  = 2'd0,
        SRC_IN    = 2'd1,
        SRC_REC   = 2'd2,
        SRC_REC_R = 2'd3
    } mac_src_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIAS,
        ST_IN_ACC,
        ST_REC_ACC,
        ST_DRAIN,
        ST_ACT,
        ST_WRITE
    } sched_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gru_sched_delay.sv
// gru_sched_delay: LAT-stage shift register that lines MAC control up with ROM read data.
module gru_sched_delay #(
    parameter int LAT = 1,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (LAT == 0) begin : g_bypass
        assign q = d;
    end else begin : g_pipe
        logic [W-1:0] stage [LAT];

        // NOTE: the stages are reset so an aborted pass cannot leave a stray mac_en in flight.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < LAT; k++) stage[k] <= '0;
            end else begin
                stage[0] <= d;
                for (int k = 1; k < LAT; k++) stage[k] <= stage[k-1];
            end
        end

        assign q = stage[LAT-1];
    end

endmodule

// File: rtl/gru_gate_scheduler.sv
// gru_gate_scheduler: walks gates z,r,h and units 0..N_UNITS-1 for the shared-MAC GRU datapath.
// Defining GRU_SCHED_PERF_EN adds a saturating busy-cycle counter on perf_cycles.
module gru_gate_scheduler
    import gru_pkg::*;
#(
    parameter int N_IN     = N_IN_DEF,
    parameter int N_UNITS  = N_UNITS_DEF,
    parameter int N_GATES  = N_GATES_DEF,
    parameter int RD_LAT   = 1,
    parameter int PIPE_LAT = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    output logic                                       busy,
    output logic                                       done,
    output logic [$clog2(N_GATES*N_UNITS)-1:0]         bias_addr,
    output logic [$clog2(N_IN*N_GATES*N_UNITS)-1:0]    w_in_addr,
    output logic [$clog2(N_UNITS*N_GATES*N_UNITS)-1:0] w_rec_addr,
    output logic [$clog2(max_int(N_IN, N_UNITS))-1:0]  vec_addr,
    output logic                                       mac_clr,
    output logic                                       mac_en,
    output logic [1:0]                                 mac_src,
    output logic [1:0]                                 gate_sel,
    output logic [$clog2(N_UNITS)-1:0]                 unit_idx,
    output logic                                       act_req,
    input  logic                                       act_ack,
    output logic                                       res_we,
    output logic [31:0]                                perf_cycles
);

    localparam int N_TOTAL  = N_GATES * N_UNITS;
    localparam int WIN_W    = $clog2(N_IN * N_TOTAL);
    localparam int WREC_W   = $clog2(N_UNITS * N_TOTAL);
    localparam int VEC_W    = $clog2(max_int(N_IN, N_UNITS));
    localparam int UNIT_W   = $clog2(N_UNITS);

    // ACT opens in the cycle the last recurrent product lands: issue -> RD_LAT -> mac_en -> PIPE_LAT.
    localparam int DRAIN_CYC = RD_LAT + PIPE_LAT - 1;
    localparam int DRAIN_W   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [DRAIN_W-1:0] DRAIN_LAST  = DRAIN_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
    localparam logic [VEC_W-1:0]   IN_LAST     = VEC_W'(N_IN - 1);
    localparam logic [VEC_W-1:0]   REC_LAST    = VEC_W'(N_UNITS - 1);
    localparam logic [UNIT_W-1:0]  UNIT_LAST   = UNIT_W'(N_UNITS - 1);
    localparam logic [1:0]         GATE_LAST   = 2'(N_GATES - 1);
    localparam logic [WIN_W-1:0]   WIN_STRIDE  = WIN_W'(N_TOTAL);
    localparam logic [WREC_W-1:0]  WREC_STRIDE = WREC_W'(N_TOTAL);

    sched_state_t         state;
    sched_state_t         state_next;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 done_q;
    logic                 last_unit;
    logic                 start_ok;
    logic                 issue_clr;
    logic                 issue_en;
    mac_src_t             issue_src;
    logic [3:0]           mac_ctl;

    assign last_unit = (gate_sel == GATE_LAST) && (unit_idx == UNIT_LAST);
    // A start coinciding with the done pulse belongs to the finished pass and is dropped.
    assign start_ok  = (state == ST_IDLE) && start && !done_q;
    assign busy      = (state != ST_IDLE);
    assign done      = done_q;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge value of its neighbours regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        issue_clr  = 1'b0;
        issue_en   = 1'b0;
        issue_src  = SRC_BIAS;
        act_req    = 1'b0;
        res_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) state_next = ST_BIAS;
            end
            ST_BIAS: begin
                issue_clr  = 1'b1;
                issue_en   = 1'b1;
                state_next = ST_IN_ACC;
            end
            ST_IN_ACC: begin
                issue_en  = 1'b1;
                issue_src = SRC_IN;
                if (vec_addr == IN_LAST) state_next = ST_REC_ACC;
            end
            ST_REC_ACC: begin
                issue_en  = 1'b1;
                // Gate h multiplies by r*h; r is complete because h only starts after all r writes.
                issue_src = (gate_sel == GATE_H) ? SRC_REC_R : SRC_REC;
                if (vec_addr == REC_LAST) state_next = (DRAIN_CYC > 0) ? ST_DRAIN : ST_ACT;
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) state_next = ST_ACT;
            end
            ST_ACT: begin
                act_req = 1'b1;
                if (act_ack) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                res_we     = 1'b1;
                state_next = last_unit ? ST_IDLE : ST_BIAS;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Address generation by stride accumulation; bias_addr doubles as the g*N_UNITS+j base.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_sel   <= GATE_Z;
            unit_idx   <= '0;
            bias_addr  <= '0;
            w_in_addr  <= '0;
            w_rec_addr <= '0;
            vec_addr   <= '0;
            drain_cnt  <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_BIAS: begin
                    w_in_addr  <= WIN_W'(bias_addr);
                    w_rec_addr <= WREC_W'(bias_addr);
                    vec_addr   <= '0;
                end
                ST_IN_ACC: begin
                    if (vec_addr == IN_LAST) begin
                        vec_addr <= '0;
                    end else begin
                        vec_addr  <= vec_addr + 1'b1;
                        w_in_addr <= w_in_addr + WIN_STRIDE;
                    end
                end
                ST_REC_ACC: begin
                    drain_cnt <= '0;
                    if (vec_addr == REC_LAST) begin
                        vec_addr <= '0;
                    end else begin
                        vec_addr   <= vec_addr + 1'b1;
                        w_rec_addr <= w_rec_addr + WREC_STRIDE;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                end
                ST_WRITE: begin
                    w_in_addr  <= '0;
                    w_rec_addr <= '0;
                    if (unit_idx != UNIT_LAST) begin
                        unit_idx  <= unit_idx + 1'b1;
                        bias_addr <= bias_addr + 1'b1;
                    end else if (gate_sel != GATE_LAST) begin
                        unit_idx  <= '0;
                        gate_sel  <= gate_sel + 2'd1;
                        bias_addr <= bias_addr + 1'b1;
                    end else begin
                        unit_idx  <= '0;
                        gate_sel  <= GATE_Z;
                        bias_addr <= '0;
                        done_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    gru_sched_delay #(
        .LAT (RD_LAT),
        .W   (4)
    ) u_mac_delay (
        .clk (clk),
        .rst (rst),
        .d   ({issue_clr, issue_en, issue_src}),
        .q   (mac_ctl)
    );

    assign mac_clr = mac_ctl[3];
    assign mac_en  = mac_ctl[2];
    assign mac_src = mac_ctl[1:0];

`ifdef GRU_SCHED_PERF_EN
    logic [31:0] perf_cnt;
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt <= '0;
            perf_q   <= '0;
        end else begin
            if (start_ok) begin
                perf_cnt <= '0;
            end else if (busy && (perf_cnt != 32'hFFFF_FFFF)) begin
                perf_cnt <= perf_cnt + 32'd1;
            end
            // Latch including the final WRITE cycle so the value is ready with done.
            if ((state == ST_WRITE) && last_unit) begin
                perf_q <= (perf_cnt == 32'hFFFF_FFFF) ? perf_cnt : perf_cnt + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_gru_gate_scheduler.sv
// tb_gru_gate_scheduler: cycle-accurate schedule model check of gru_gate_scheduler.
module tb_gru_gate_scheduler;
    import gru_pkg::*;

    localparam int N_IN     = 24;
    localparam int N_UNITS  = 24;
    localparam int N_GATES  = 3;
    localparam int RD_LAT   = 1;
    localparam int PIPE_LAT = 2;
    localparam int N_TOTAL  = N_GATES * N_UNITS;
    localparam int STRIDE   = N_GATES * N_UNITS;
    localparam int UNIT_W   = $clog2(N_UNITS);

    // Offsets inside one unit's slot: BIAS at 0, inputs from 1, recurrent after them.
    localparam int OFF_REC    = 1 + N_IN;
    localparam int ISSUE_LAST = OFF_REC + N_UNITS - 1;
    localparam int OFF_ACT    = ISSUE_LAST + RD_LAT + PIPE_LAT;

    logic        clk;
    logic        rst;
    logic        start;
    logic        act_ack;
    logic        busy;
    logic        done;
    logic [$clog2(N_TOTAL)-1:0]          bias_addr;
    logic [$clog2(N_IN*N_TOTAL)-1:0]     w_in_addr;
    logic [$clog2(N_UNITS*N_TOTAL)-1:0]  w_rec_addr;
    logic [$clog2(N_IN)-1:0]             vec_addr;
    logic        mac_clr;
    logic        mac_en;
    logic [1:0]  mac_src;
    logic [1:0]  gate_sel;
    logic [UNIT_W-1:0] unit_idx;
    logic        act_req;
    logic        res_we;
    logic [31:0] perf_cycles;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    gru_gate_scheduler #(
        .N_IN     (N_IN),
        .N_UNITS  (N_UNITS),
        .N_GATES  (N_GATES),
        .RD_LAT   (RD_LAT),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .bias_addr   (bias_addr),
        .w_in_addr   (w_in_addr),
        .w_rec_addr  (w_rec_addr),
        .vec_addr    (vec_addr),
        .mac_clr     (mac_clr),
        .mac_en      (mac_en),
        .mac_src     (mac_src),
        .gate_sel    (gate_sel),
        .unit_idx    (unit_idx),
        .act_req     (act_req),
        .act_ack     (act_ack),
        .res_we      (res_we),
        .perf_cycles (perf_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int cyc, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ctrl_word(input logic b, input logic dn, input logic en, input logic clr,
                                              input logic req, input logic we, input logic [1:0] gs,
                                              input logic [UNIT_W-1:0] ui);
        return 64'({b, dn, en, clr, req, we, gs, ui});
    endfunction

    // One pass from a start pulse in the current cycle (cycle 0). dly[u] is how many cycles
    // act_ack lags act_req for unit u; tied holds act_ack high throughout. abort_at>0 resets there.
    task automatic run_pass(input int dly [N_TOTAL], input int abort_at, input bit tied);
        int ustart [N_TOTAL+1];
        int pass_end, u, off, g, j, io, exp_src;
        int we_seen, first_h_we, busy_seen, req_len0, exp_perf;
        bit en_x, clr_x, req_x, we_x;

        ustart[0] = 1;
        for (int k = 0; k < N_TOTAL; k++) ustart[k+1] = ustart[k] + OFF_ACT + dly[k] + 2;
        pass_end = ustart[N_TOTAL];

        start   = 1'b1;
        act_ack = tied;
        u = 0; we_seen = 0; first_h_we = -1; busy_seen = 0; req_len0 = 0;

        for (int cyc = 1; cyc <= pass_end; cyc++) begin
            tick();
            // Both start pulses land while a pass owns the sequencer and must be ignored.
            start = (cyc == 200) || (cyc == pass_end);
            if (busy === 1'b1) busy_seen++;
            if (res_we === 1'b1) we_seen++;
            if (mac_en === 1'b1 && mac_src === SRC_REC_R && first_h_we < 0) first_h_we = we_seen;
            if (cyc < pass_end) begin
                while (cyc >= ustart[u+1]) u++;
                off = cyc - ustart[u];
                g = u / N_UNITS;
                j = u % N_UNITS;
                io = off - RD_LAT;
                en_x  = (io >= 0) && (io <= ISSUE_LAST);
                clr_x = (io == 0);
                req_x = (off >= OFF_ACT) && (off <= OFF_ACT + dly[u]);
                we_x  = (off == OFF_ACT + dly[u] + 1);
                if (u == 0 && act_req === 1'b1) req_len0++;
                check("ctrl", cyc, ctrl_word(busy, done, mac_en, mac_clr, act_req, res_we, gate_sel, unit_idx),
                      ctrl_word(1'b1, 1'b0, en_x, clr_x, req_x, we_x, 2'(g), UNIT_W'(j)));
                if (en_x) begin
                    if (io == 0) exp_src = SRC_BIAS;
                    else if (io < OFF_REC) exp_src = SRC_IN;
                    else exp_src = (g == GATE_H) ? SRC_REC_R : SRC_REC;
                    check("mac_src", cyc, mac_src, exp_src);
                end
                if (off == 0) check("bias_addr", cyc, bias_addr, g * N_UNITS + j);
                if (off >= 1 && off < OFF_REC) begin
                    check("w_in_addr", cyc, w_in_addr, (off - 1) * STRIDE + g * N_UNITS + j);
                    check("vec_in", cyc, vec_addr, off - 1);
                end
                if (off >= OFF_REC && off <= ISSUE_LAST) begin
                    check("w_rec_addr", cyc, w_rec_addr, (off - OFF_REC) * STRIDE + g * N_UNITS + j);
                    check("vec_rec", cyc, vec_addr, off - OFF_REC);
                end
                act_ack = tied ? 1'b1 : (off == OFF_ACT + dly[u]);
            end else begin
                check("done_cycle", cyc, {busy, done, mac_en, act_req, res_we}, 5'b01000);
                act_ack = tied;
            end
            if (cyc == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("abort_ctrl", cyc + 1, {busy, done, mac_en, mac_clr, act_req, res_we}, 6'b0);
                check("abort_addr", cyc + 1, {bias_addr, w_in_addr, w_rec_addr, vec_addr}, 64'd0);
                return;
            end
        end

        start = 1'b0;
        tick();
        check("after_done", pass_end + 1, {busy, done, res_we}, 3'b000);
        check("we_count", pass_end, we_seen, N_TOTAL);
        check("first_h_mac", pass_end, first_h_we, 2 * N_UNITS);
        check("busy_cycles", pass_end, busy_seen, pass_end - 1);
        check("act_req_len_u0", pass_end, req_len0, dly[0] + 1);
`ifdef GRU_SCHED_PERF_EN
        exp_perf = pass_end - 1;
`else
        exp_perf = 0;
`endif
        check("perf_cycles", pass_end, perf_cycles, exp_perf);
    endtask

    task automatic idle_gap(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            check("idle", k, {busy, done, mac_en, act_req, res_we}, 5'b0);
        end
    endtask

    initial begin
        int zero_dly [N_TOTAL];
        int rnd_dly  [N_TOTAL];

        for (int k = 0; k < N_TOTAL; k++) begin
            zero_dly[k] = 0;
            rnd_dly[k]  = $urandom_range(0, 7);
        end
        rnd_dly[0] = 7;

        rst = 1'b1; start = 1'b0; act_ack = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_ctrl", 0, {busy, done, mac_en, mac_clr, act_req, res_we}, 6'b0);
        check("reset_addr", 0, {bias_addr, w_in_addr, w_rec_addr, vec_addr}, 64'd0);
        check("reset_perf", 0, perf_cycles, 0);
        idle_gap(2);

        run_pass(zero_dly, -1, 1'b1);
        idle_gap($urandom_range(2, 6));

        run_pass(rnd_dly, -1, 1'b0);
        idle_gap($urandom_range(2, 6));

        act_ack = 1'b1;
        run_pass(zero_dly, 500, 1'b1);
        idle_gap(50);

        run_pass(zero_dly, -1, 1'b1);
        idle_gap(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
